linebuffer_reader: RTL and testbench
====================================

LINEBUFFER_READER -- requirements
Module: linebuffer_reader

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 8: pixel/RAM word width in bits.
REQ-002 SHALL have parameter C_ADDRESS_WIDTH, default 8: line RAM address width in bits; the line holds up to 2**C_ADDRESS_WIDTH words.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is rising-edge clocked.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request to read out one line; sampled only in IDLE.
REQ-006 SHALL have port sof, input, 1: start-of-frame flag, latched with start.
REQ-007 SHALL have port last_addr, input, C_ADDRESS_WIDTH: line length minus 1, latched with start.
REQ-008 SHALL have port busy, output, 1: high in every state other than IDLE.
REQ-009 SHALL have port done, output, 1: one-cycle pulse after the last beat is accepted.
REQ-010 SHALL have port rd_en, output, 1: RAM read strobe.
REQ-011 SHALL have port rd_addr, output, C_ADDRESS_WIDTH: RAM read address.
REQ-012 SHALL have port rd_data, input, C_DATA_WIDTH: RAM read data, valid exactly one cycle after the rd_en/rd_addr cycle.
REQ-013 SHALL have ports m_axis_tvalid (output, 1), m_axis_tdata (output, C_DATA_WIDTH), m_axis_tuser (output, 1), m_axis_tlast (output, 1) and m_axis_tready (input, 1) forming the AXI4-Stream master.

Function
REQ-014 SHALL implement states IDLE, RUN and DRAIN: IDLE->RUN on start; RUN->DRAIN after the read of the final address is issued; DRAIN->IDLE when the tlast beat is accepted (tvalid&tready).
REQ-015 SHALL ignore start while busy, and SHALL NOT alter the latched sof or last_addr.
REQ-016 SHALL issue reads at addresses 0,1,...,last_addr in order, exactly once each, with rd_en high only on issue cycles.
REQ-017 SHALL capture returned data in a 2-entry output FIFO and SHALL issue a read only when (FIFO occupancy + reads in flight - beats popped this cycle) < 2, so the FIFO never overflows.
REQ-018 SHALL assert rd_en/rd_addr=0 in the cycle after start is sampled, and SHALL present the first beat with tvalid in the third cycle after the start cycle.
REQ-019 SHALL sustain one beat per cycle while tready is held high.
REQ-020 SHALL hold tdata, tuser and tlast stable while tvalid=1 and tready=0, and SHALL NOT deassert tvalid until the beat is accepted.
REQ-021 SHALL set tuser to the latched sof on the first beat of the line only, and 0 on all other beats.
REQ-022 SHALL set tlast only on the beat read from the final address; when last_addr=0, the single beat SHALL carry both tuser=sof and tlast=1.
REQ-023 SHALL pulse done for exactly one cycle, in the cycle after the tlast beat is accepted; busy SHALL be low in that same cycle, and a start in that cycle SHALL be accepted.

Reset
REQ-024 SHALL on reset force state IDLE, empty the FIFO, discard in-flight reads, and drive busy, done, rd_en, m_axis_tvalid, m_axis_tuser and m_axis_tlast to 0 and rd_addr to 0; m_axis_tdata SHALL be 0.
REQ-025 SHALL, on reset asserted mid-line, abort the line in the next cycle without emitting done or further beats; RAM data returning after reset SHALL be dropped.
REQ-026 SHALL give reset priority over start in the same cycle.

Configuration
REQ-027 SHALL, when macro LINEBUFFER_READER_REVERSE_EN is defined, read addresses last_addr down to 0 (horizontal mirror), with tuser on the first beat read (last_addr) and tlast on the beat read from address 0.
REQ-028 SHALL, when LINEBUFFER_READER_REVERSE_EN is undefined, read in ascending order only, with no mirror logic present.

Verification
REQ-029 SHALL cover: last_addr=7, sof=1, tready=1 -> rd_addr 0..7 on consecutive cycles; 8 beats on consecutive cycles, the first in the third cycle after start; tuser on beat 0 only; tlast on beat 7; done one cycle later.
REQ-030 SHALL cover: last_addr=7 with tready toggling 1,0,0,1,... -> no lost or duplicated data, tdata stable while stalled, at most 2 outstanding entries.
REQ-031 SHALL cover: last_addr=0, sof=0 -> one beat with tuser=0 and tlast=1, followed by done.
REQ-032 SHALL cover: start pulsed again mid-line with last_addr=3 -> ignored; the original 8-beat line completes unchanged.
REQ-033 SHALL cover: reset asserted after beat 3 of 8 -> tvalid=0 and busy=0 in the next cycle, no done; a new start then yields a full, correct line.
REQ-034 SHALL cover: with LINEBUFFER_READER_REVERSE_EN defined and last_addr=3 -> rd_addr 3,2,1,0; tuser on the data from address 3; tlast on the data from address 0.

Source files
------------

// File: rtl/linebuffer_reader.sv
// Reads one line from a synchronous line RAM and streams it out as AXI4-Stream beats.
// Define LINEBUFFER_READER_REVERSE_EN to read the line mirrored (last_addr down to 0).
module linebuffer_reader #(
  parameter int C_DATA_WIDTH    = 8,
  parameter int C_ADDRESS_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       sof,
  input  logic [C_ADDRESS_WIDTH-1:0] last_addr,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [C_ADDRESS_WIDTH-1:0] rd_addr,
  input  logic [C_DATA_WIDTH-1:0]    rd_data,
  output logic                       m_axis_tvalid,
  output logic [C_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                       m_axis_tuser,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready
);

  localparam logic [C_ADDRESS_WIDTH-1:0] ADDR_ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                      state_q, state_d;
  logic [C_ADDRESS_WIDTH-1:0]  addr_q, addr_d;
  logic                        first_q, first_d;
  logic                        sof_q;
`ifndef LINEBUFFER_READER_REVERSE_EN
  logic [C_ADDRESS_WIDTH-1:0]  last_q;
`endif

  logic                        infl_q, infl_user_q, infl_last_q;
  logic [C_DATA_WIDTH-1:0]     fifo_data_q [2];
  logic [1:0]                  fifo_user_q, fifo_last_q;
  logic                        wr_ptr_q, rd_ptr_q;
  logic [1:0]                  count_q;
  logic                        done_q;

  logic                        pop, push, can_issue, final_addr;
  logic                        head_user, head_last;
  logic [2:0]                  occ;

  assign push      = infl_q;
  assign pop       = m_axis_tvalid & m_axis_tready;
  // Count a beat leaving this cycle as free space so the stream sustains one beat per cycle.
  assign occ       = {1'b0, count_q} + {2'b00, infl_q} - {2'b00, pop};
  assign can_issue = (occ < 3'd2);
  assign head_user = fifo_user_q[rd_ptr_q];
  assign head_last = fifo_last_q[rd_ptr_q];

`ifdef LINEBUFFER_READER_REVERSE_EN
  assign final_addr = (addr_q == '0);
`else
  assign final_addr = (addr_q == last_q);
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    first_d = first_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          first_d = 1'b1;
`ifdef LINEBUFFER_READER_REVERSE_EN
          addr_d  = last_addr;
`else
          addr_d  = '0;
`endif
        end
      end
      RUN: begin
        if (can_issue) begin
          rd_en   = 1'b1;
          first_d = 1'b0;
          if (final_addr) begin
            state_d = DRAIN;
          end else begin
`ifdef LINEBUFFER_READER_REVERSE_EN
            addr_d = addr_q - ADDR_ONE;
`else
            addr_d = addr_q + ADDR_ONE;
`endif
          end
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      first_q <= 1'b0;
      sof_q   <= 1'b0;
`ifndef LINEBUFFER_READER_REVERSE_EN
      last_q  <= '0;
`endif
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      first_q <= first_d;
      done_q  <= (state_q == DRAIN) && pop && head_last;
      if (state_q == IDLE && start) begin
        sof_q  <= sof;
`ifndef LINEBUFFER_READER_REVERSE_EN
        last_q <= last_addr;
`endif
      end
    end
  end

  // Tags travel with the read so the FIFO entry knows whether it opens or closes the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      infl_q      <= 1'b0;
      infl_user_q <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      infl_q      <= rd_en;
      infl_user_q <= rd_en & first_q & sof_q;
      infl_last_q <= rd_en & final_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
      end
      fifo_user_q <= '0;
      fifo_last_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= rd_data;
        fifo_user_q[wr_ptr_q] <= infl_user_q;
        fifo_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign rd_addr       = (state_q == RUN) ? addr_q : '0;
  assign m_axis_tvalid = (count_q != 2'd0);
  assign m_axis_tdata  = m_axis_tvalid ? fifo_data_q[rd_ptr_q] : '0;
  assign m_axis_tuser  = m_axis_tvalid & head_user;
  assign m_axis_tlast  = m_axis_tvalid & head_last;

endmodule

// File: tb/tb_linebuffer_reader.sv
// Directed self-checking bench for linebuffer_reader with a one-cycle-latency RAM model.
module tb_linebuffer_reader;
  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          sof = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic          busy, done, rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          m_axis_tvalid, m_axis_tuser, m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tready = 1'b1;

  logic [DW-1:0] ram [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  linebuffer_reader #(.C_DATA_WIDTH(DW), .C_ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .sof(sof), .last_addr(last_addr),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready)
  );

  // Returns junk when not strobed, so a capture on the wrong cycle is visible.
  always @(posedge clk) rd_data <= rd_en ? ram[rd_addr] : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] la, input int k);
`ifdef LINEBUFFER_READER_REVERSE_EN
    return la - AW'(k);
`else
    return AW'(k);
`endif
  endfunction

  task automatic idle_cycle();
    start = 1'b0;
    @(posedge clk); #2;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  // Streams one line; stall=1 drives tready 1,0,0,1,..; rst_after>0 resets after that many beats.
  task automatic run_line(input logic [AW-1:0] la, input logic s, input int stall,
                          input int rst_after, input int mid_start);
    int issued = 0;
    int accepted = 0;
    int n = int'(la) + 1;
    logic pv = 1'b0, pr = 1'b0, pu = 1'b0, pl = 1'b0;
    logic [DW-1:0] pd = '0;
    logic exp_done = 1'b0;
    logic rst_next = 1'b0;
    start = 1'b1; sof = s; last_addr = la; m_axis_tready = 1'b1;
    #1;
    chk("start_cycle_busy", busy, 0);
    @(posedge clk); #1;
    for (int c = 1; c <= 200; c++) begin
      if (rst_next) begin
        reset = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; #1;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        for (int k = 0; k < 4; k++) begin
          @(posedge clk); #2;
          chk("rst_quiet_tvalid", m_axis_tvalid, 0);
          chk("rst_quiet_done", done, 0);
        end
        return;
      end
      start = (mid_start != 0 && c == 2);
      last_addr = start ? 8'd3 : ~la;
      sof = ~s;
      m_axis_tready = (stall != 0) ? (c % 3 == 0) : 1'b1;
      #1;
      chk("done", done, exp_done);
      chk("busy", busy, !exp_done);
      if (exp_done) return;
      if (stall == 0) begin
        chk("rd_en_seq", rd_en, c <= n);
        chk("tvalid_seq", m_axis_tvalid, c >= 3 && c <= n + 2);
      end
      if (c == 1) chk("first_rd_en", rd_en, 1);
      if (c == 3) chk("first_beat_valid", m_axis_tvalid, 1);
      if (rd_en) begin
        chk("rd_addr", rd_addr, exp_addr(la, issued));
        issued++;
        chk("rd_count_bound", issued <= n, 1);
      end
      if (pv && !pr) begin
        chk("hold_tvalid", m_axis_tvalid, 1);
        chk("hold_tdata", m_axis_tdata, pd);
        chk("hold_tuser", m_axis_tuser, pu);
        chk("hold_tlast", m_axis_tlast, pl);
      end
      exp_done = 1'b0;
      if (m_axis_tvalid) begin
        chk("tdata", m_axis_tdata, ram[exp_addr(la, accepted)]);
        chk("tuser", m_axis_tuser, s && accepted == 0);
        chk("tlast", m_axis_tlast, accepted == n - 1);
        if (m_axis_tready) begin
          accepted++;
          exp_done = (accepted == n);
        end
      end
      chk("outstanding", (issued - accepted) <= 2, 1);
      pv = m_axis_tvalid; pr = m_axis_tready;
      pd = m_axis_tdata; pu = m_axis_tuser; pl = m_axis_tlast;
      if (rst_after > 0 && accepted == rst_after) rst_next = 1'b1;
      @(posedge clk); #1;
    end
    chk("timeout_done", done, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7 + 3);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy0", busy, 0);
    chk("rst_done0", done, 0);
    chk("rst_rd_en0", rd_en, 0);
    chk("rst_rd_addr0", rd_addr, 0);
    chk("rst_tvalid0", m_axis_tvalid, 0);
    chk("rst_tdata0", m_axis_tdata, 0);
    chk("rst_tuser0", m_axis_tuser, 0);
    chk("rst_tlast0", m_axis_tlast, 0);

    start = 1'b1; last_addr = 8'd5; sof = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; #1;
    chk("rst_prio_busy", busy, 0);
    chk("rst_prio_rd_en", rd_en, 0);
    idle_cycle();

    run_line(8'd7, 1'b1, 0, 0, 0);
    idle_cycle();
    run_line(8'd7, 1'b1, 1, 0, 0);
    run_line(8'd0, 1'b0, 0, 0, 0);
    idle_cycle();
    run_line(8'd7, 1'b1, 0, 0, 1);
    idle_cycle();
    run_line(8'd7, 1'b1, 0, 3, 0);
    run_line(8'd7, 1'b0, 1, 0, 0);
    idle_cycle();
    run_line(8'd3, 1'b1, 0, 0, 0);
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
